rtc_rgs_mc: RTL
===============

# rtc_rgs_mc

Multi-channel RTC register interface for software. It sits between the 32-bit on-chip bus and the RTC core. It exposes tick increment, offset, clear, PPS-width and interval-select controls, and returns a coherent snapshot of current time. It also captures up to four PPS timestamp channels, each with sticky status, overflow detection, a W1C clear and a maskable interrupt.

## Interface
- BASE_ADDR, 24'h000000: compared against bus2ip_addr_i[31:8].
- NUM_PTS, 1: number of timestamp capture channels; legal range 1..4.
- PULSE_W, 3: width in clocks of the self-clearing control pulses; legal range 1..8.
- TICK_INC_RST, 32'h0: reset value of tick_inc_o.

Ports (clock and reset first):
- bus2ip_clk  in  1  clock.
- bus2ip_rst_n  in  1  asynchronous, active-low reset.
- bus2ip_addr_i  in  32  byte address.
- bus2ip_data_i  in  32  write data.
- bus2ip_rd_ce_i  in  1  read strobe, active high, one cycle per access.
- bus2ip_wr_ce_i  in  1  write strobe, active high, one cycle per access.
- ip2bus_data_o  out  32  registered read data.
- ip2bus_rdack_o  out  1  read acknowledge pulse.
- ip2bus_wrack_o  out  1  write acknowledge pulse.
- rtc_std_i  in  80  current time: {sec[47:0], ns[31:0]}.
- rtc_fns_i  in  16  current fractional ns.
- pts_std_i  in  80*NUM_PTS  per-channel timestamp; channel c occupies [80c+79:80c].
- pts_fns_i  in  16*NUM_PTS  per-channel fractional ns.
- pts_vld_i  in  NUM_PTS  per-channel capture strobe, one-cycle pulse, synchronous to bus2ip_clk.
- tick_inc_o  out  32  tick increment.
- ns_offset_o  out  32  ns offset.
- sc_offset_o  out  48  seconds offset.
- offset_valid_o  out  1  offset-apply pulse, PULSE_W cycles.
- clear_rtc_o  out  1  RTC clear pulse, PULSE_W cycles.
- pps_width_o  out  32  PPS width.
- intxms_sel_o  out  1  0 selects 10 ms; 1 selects 7.8125 ms.
- irq_o  out  1  level interrupt = |(status & mask).

## Operation
- An access is selected when bus2ip_addr_i[31:8]==BASE_ADDR. Offsets are decoded on [7:0].
- Unselected accesses produce no ack and no state change.
- Selected unmapped offsets are acked, read 0 and ignore writes.

Register map:
- 0x00 CTL
  - bit0 offset_valid (SC).
  - bit1 clear_rtc (SC).
  - bit2 intxms_sel (RW).
  - Bits 0/1 read 1 while the corresponding pulse is active.
- 0x04 TICK_INC, RW.
- 0x08 NS_OFST, RW.
- 0x0C SC_OFST_HI: sc_offset[47:16], RW.
- 0x10 SC_OFST_LO: [15:0] holds sc_offset[15:0], RW; upper bits read 0.
- 0x14 CUR_TM0
  - Read returns rtc_std_i[79:48].
  - The same read loads the shadow with {rtc_std_i[47:0], rtc_fns_i}.
- 0x18 CUR_TM1: reads shadow[63:32] = {sec[15:0], ns[31:16]}.
- 0x1C CUR_TM2: reads shadow[31:0] = {ns[15:0], fns}.
- 0x20 PPS_W, RW.
- 0x24 STATUS
  - [3:0] cap_vld per channel.
  - [11:8] ovf per channel.
  - W1C; bits for channels >= NUM_PTS read 0.
- 0x28 IRQ_MASK: [3:0] RW; bits >= NUM_PTS read 0.
- 0x30+0x10*c, c<NUM_PTS: per-channel timestamp words.
  - +0 reads cap[79:48].
  - +4 reads cap[47:16].
  - +8 reads {cap[15:0], cap_fns}.

Capture rule, per channel:
- pts_vld with cap_vld=0: load the capture register and set cap_vld.
- pts_vld with cap_vld=1: keep the held data and set ovf.
- pts_vld in the same cycle as a W1C of cap_vld: load new data; cap_vld stays 1; ovf is unchanged.
- ovf is cleared only by W1C.

Self-clearing pulses:
- A write of 1 to CTL bit0 or bit1 loads a per-bit counter with PULSE_W.
- The output is high while the counter is nonzero.
- A rewrite during an active pulse reloads the counter, extending the pulse.
- Writing 0 has no effect on an active pulse.
- Bit2 is written on every CTL write.

## Timing
- Reset values:
  - tick_inc_o = TICK_INC_RST.
  - All other outputs, the shadow, capture registers, status and mask = 0.
- A read strobe sampled at edge N gives ip2bus_data_o valid and ip2bus_rdack_o=1 for the cycle following edge N (1-cycle latency). Data holds until the next read.
- A write strobe sampled at edge N updates the register at edge N and pulses ip2bus_wrack_o after edge N.
- A CTL write at edge N drives offset_valid_o / clear_rtc_o high from after edge N through edge N+PULSE_W.
- irq_o is registered and follows status/mask changes by one cycle.
- Reset mid-pulse or mid-capture aborts immediately; all state returns to reset values.

## Test plan
- Reset, then read all registers -> TICK_INC = TICK_INC_RST, everything else 0, and rdack 1 cycle after each read.
- Write SC_OFST_HI=32'h12345678 and SC_OFST_LO=32'hFFFF9ABC -> sc_offset_o=48'h123456789ABC and LO reads 32'h00009ABC.
- With PULSE_W=3, write CTL=3'b011 -> both pulses high exactly 3 cycles; CTL reads 3'b011 during the pulse and 3'b000 after. A rewrite at cycle 2 extends the pulse to 5 cycles total.
- Read CUR_TM0, let rtc_std_i change, then read CUR_TM1/2 -> the values match the time at the CUR_TM0 read.
- Channel 1: pts_vld with ts A -> STATUS=0x002 and irq_o=1 if mask bit1 set. A second pts_vld with B -> data stays A and STATUS=0x202. W1C 0x202 -> STATUS=0 and irq_o=0.
- W1C of cap_vld coincident with pts_vld -> new data loaded, cap_vld=1, ovf=0. Access with a wrong base address -> no ack and no change.

Source files
------------

// File: rtl/rtc_rgs_mc.sv
// Software register interface for the multi-channel RTC: control and offset registers,
// a coherent current-time snapshot, and per-channel PPS timestamp capture with interrupts.
module rtc_rgs_mc #(
    parameter logic [23:0] BASE_ADDR    = 24'h000000,
    parameter int          NUM_PTS      = 1,
    parameter int          PULSE_W      = 3,
    parameter logic [31:0] TICK_INC_RST = 32'h0
) (
    input  logic                    bus2ip_clk,
    input  logic                    bus2ip_rst_n,
    input  logic [31:0]             bus2ip_addr_i,
    input  logic [31:0]             bus2ip_data_i,
    input  logic                    bus2ip_rd_ce_i,
    input  logic                    bus2ip_wr_ce_i,
    output logic [31:0]             ip2bus_data_o,
    output logic                    ip2bus_rdack_o,
    output logic                    ip2bus_wrack_o,
    input  logic [79:0]             rtc_std_i,
    input  logic [15:0]             rtc_fns_i,
    input  logic [80*NUM_PTS-1:0]   pts_std_i,
    input  logic [16*NUM_PTS-1:0]   pts_fns_i,
    input  logic [NUM_PTS-1:0]      pts_vld_i,
    output logic [31:0]             tick_inc_o,
    output logic [31:0]             ns_offset_o,
    output logic [47:0]             sc_offset_o,
    output logic                    offset_valid_o,
    output logic                    clear_rtc_o,
    output logic [31:0]             pps_width_o,
    output logic                    intxms_sel_o,
    output logic                    irq_o
);

    localparam logic [3:0] PULSE_LD = 4'(PULSE_W);

    logic              sel;
    logic              rd_en;
    logic              wr_en;
    logic [7:0]        ofs;

    logic [31:0]       tick_inc_q;
    logic [31:0]       ns_ofst_q;
    logic [47:0]       sc_ofst_q;
    logic [31:0]       pps_w_q;
    logic              intxms_q;
    logic [3:0]        ofs_cnt;
    logic [3:0]        clr_cnt;
    logic [63:0]       shadow_q;
    logic [79:0]       cap_std_q [NUM_PTS];
    logic [15:0]       cap_fns_q [NUM_PTS];
    logic [NUM_PTS-1:0] cap_vld_q;
    logic [NUM_PTS-1:0] ovf_q;
    logic [NUM_PTS-1:0] mask_q;
    logic [NUM_PTS-1:0] w1c_cap;
    logic [NUM_PTS-1:0] w1c_ovf;
    logic [3:0]        cap4;
    logic [3:0]        ovf4;
    logic [3:0]        mask4;
    logic [31:0]       rd_mux;
    logic              ctl_wr;

    assign sel    = (bus2ip_addr_i[31:8] == BASE_ADDR);
    assign ofs    = bus2ip_addr_i[7:0];
    assign rd_en  = sel && bus2ip_rd_ce_i;
    assign wr_en  = sel && bus2ip_wr_ce_i;
    assign ctl_wr = wr_en && (ofs == 8'h00);

    assign w1c_cap = (wr_en && ofs == 8'h24) ? bus2ip_data_i[NUM_PTS-1:0]   : '0;
    assign w1c_ovf = (wr_en && ofs == 8'h24) ? bus2ip_data_i[8 +: NUM_PTS]  : '0;

    always_comb begin
        cap4  = '0;
        ovf4  = '0;
        mask4 = '0;
        cap4[NUM_PTS-1:0]  = cap_vld_q;
        ovf4[NUM_PTS-1:0]  = ovf_q;
        mask4[NUM_PTS-1:0] = mask_q;
    end

    always_comb begin
        rd_mux = '0;
        case (ofs)
            8'h00: rd_mux = {29'b0, intxms_q, (clr_cnt != 4'd0), (ofs_cnt != 4'd0)};
            8'h04: rd_mux = tick_inc_q;
            8'h08: rd_mux = ns_ofst_q;
            8'h0C: rd_mux = sc_ofst_q[47:16];
            8'h10: rd_mux = {16'b0, sc_ofst_q[15:0]};
            8'h14: rd_mux = rtc_std_i[79:48];
            8'h18: rd_mux = shadow_q[63:32];
            8'h1C: rd_mux = shadow_q[31:0];
            8'h20: rd_mux = pps_w_q;
            8'h24: rd_mux = {20'b0, ovf4, 4'b0, cap4};
            8'h28: rd_mux = {28'b0, mask4};
            default: ;
        endcase
        for (int c = 0; c < NUM_PTS; c++) begin
            if (ofs == 8'(48 + 16*c)) rd_mux = cap_std_q[c][79:48];
            if (ofs == 8'(52 + 16*c)) rd_mux = cap_std_q[c][47:16];
            if (ofs == 8'(56 + 16*c)) rd_mux = {cap_std_q[c][15:0], cap_fns_q[c]};
        end
    end

    // Bus response and software-writable registers
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            ip2bus_data_o  <= '0;
            ip2bus_rdack_o <= 1'b0;
            ip2bus_wrack_o <= 1'b0;
            tick_inc_q     <= TICK_INC_RST;
            ns_ofst_q      <= '0;
            sc_ofst_q      <= '0;
            pps_w_q        <= '0;
            intxms_q       <= 1'b0;
            mask_q         <= '0;
            shadow_q       <= '0;
        end else begin
            ip2bus_rdack_o <= rd_en;
            ip2bus_wrack_o <= wr_en;
            if (rd_en) ip2bus_data_o <= rd_mux;
            // Reading the seconds MSW freezes the rest of the time for the follow-up reads
            if (rd_en && ofs == 8'h14) shadow_q <= {rtc_std_i[47:0], rtc_fns_i};
            if (wr_en) begin
                case (ofs)
                    8'h00: intxms_q          <= bus2ip_data_i[2];
                    8'h04: tick_inc_q        <= bus2ip_data_i;
                    8'h08: ns_ofst_q         <= bus2ip_data_i;
                    8'h0C: sc_ofst_q[47:16]  <= bus2ip_data_i;
                    8'h10: sc_ofst_q[15:0]   <= bus2ip_data_i[15:0];
                    8'h20: pps_w_q           <= bus2ip_data_i;
                    8'h28: mask_q            <= bus2ip_data_i[NUM_PTS-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Self-clearing pulses: a write of 1 (re)loads the counter, so rewrites extend the pulse
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            ofs_cnt <= '0;
            clr_cnt <= '0;
        end else begin
            if (ctl_wr && bus2ip_data_i[0]) ofs_cnt <= PULSE_LD;
            else if (ofs_cnt != 4'd0)       ofs_cnt <= ofs_cnt - 4'd1;
            if (ctl_wr && bus2ip_data_i[1]) clr_cnt <= PULSE_LD;
            else if (clr_cnt != 4'd0)       clr_cnt <= clr_cnt - 4'd1;
        end
    end

    // Timestamp capture; a W1C of cap_vld in the same cycle makes room for the new sample
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            for (int c = 0; c < NUM_PTS; c++) begin
                cap_std_q[c] <= '0;
                cap_fns_q[c] <= '0;
            end
            cap_vld_q <= '0;
            ovf_q     <= '0;
            irq_o     <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_PTS; c++) begin
                if (pts_vld_i[c] && (!cap_vld_q[c] || w1c_cap[c])) begin
                    cap_std_q[c] <= pts_std_i[80*c +: 80];
                    cap_fns_q[c] <= pts_fns_i[16*c +: 16];
                    cap_vld_q[c] <= 1'b1;
                end else if (w1c_cap[c]) begin
                    cap_vld_q[c] <= 1'b0;
                end
                if (pts_vld_i[c] && cap_vld_q[c] && !w1c_cap[c]) ovf_q[c] <= 1'b1;
                else if (w1c_ovf[c])                             ovf_q[c] <= 1'b0;
            end
            irq_o <= |(cap_vld_q & mask_q);
        end
    end

    assign tick_inc_o     = tick_inc_q;
    assign ns_offset_o    = ns_ofst_q;
    assign sc_offset_o    = sc_ofst_q;
    assign pps_width_o    = pps_w_q;
    assign intxms_sel_o   = intxms_q;
    assign offset_valid_o = (ofs_cnt != 4'd0);
    assign clear_rtc_o    = (clr_cnt != 4'd0);

endmodule
